div_32: RTL and testbench

DIV_32 -- requirements
Module: div_32

---
 rtl/div_32_if.sv | 23 ++
 rtl/div_32.sv | 144 ++++++++++++++
 tb/tb_div_32.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/div_32_if.sv
// Handshake and operand bus for div_32.
// master: the requester driving start/operands; slave: the divider.
interface div_32_if;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div_zero;

    modport master (
        output start, sign, a, b,
        input  busy, done, q, r, div_zero
    );

    modport slave (
        input  start, sign, a, b,
        output busy, done, q, r, div_zero
    );
endinterface

// File: rtl/div_32.sv
// div_32: 32-bit iterative restoring divider, one quotient bit per cycle.
// Latency is 32 RUN cycles plus one DONE cycle; a zero divisor skips RUN.
// Optional macro DIV_SIGNED_EN adds two's-complement division selected by
// bus.sign; without it the sign input is ignored and all division is unsigned.
module div_32 (
    input logic       clk,
    input logic       rst,
    div_32_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [5:0]  r_cnt;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic        r_div_zero;

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_rp;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_a_in;
    logic [31:0] w_b_in;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_cnt == 6'd31);

    // One restoring step: shift in the next dividend bit, try to subtract.
    always_comb begin
        w_rp       = {r_rem[30:0], r_dividend[31]};
        w_diff     = {1'b0, w_rp} - {1'b0, r_divisor};
        w_rem_next = w_diff[32] ? w_rp : w_diff[31:0];
        w_quo_next = {r_quo[30:0], ~w_diff[32]};
    end

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    // Signed mode divides magnitudes, then restores the signs on completion.
    always_comb begin
        w_a_neg   = bus.sign & bus.a[31];
        w_b_neg   = bus.sign & bus.b[31];
        w_a_in    = w_a_neg ? (32'd0 - bus.a) : bus.a;
        w_b_in    = w_b_neg ? (32'd0 - bus.b) : bus.b;
        w_q_final = r_neg_q ? (32'd0 - w_quo_next) : w_quo_next;
        w_r_final = r_neg_r ? (32'd0 - w_rem_next) : w_rem_next;
    end

    // Sign flags captured alongside the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    // Unsigned only: operands and results pass straight through.
    always_comb begin
        w_a_in    = bus.a;
        w_b_in    = bus.b;
        w_q_final = w_quo_next;
        w_r_final = w_rem_next;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = (bus.b == '0) ? DONE : RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        bus.busy = (r_state == RUN);
        bus.done = (r_state == DONE);
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            if (bus.b == '0) begin
                r_q        <= '1;
                r_r        <= bus.a;
                r_div_zero <= 1'b1;
            end else begin
                r_dividend <= w_a_in;
                r_divisor  <= w_b_in;
                r_rem      <= '0;
                r_quo      <= '0;
                r_cnt      <= '0;
            end
        end else if (r_state == RUN) begin
            r_dividend <= {r_dividend[30:0], 1'b0};
            r_rem      <= w_rem_next;
            r_quo      <= w_quo_next;
            r_cnt      <= r_cnt + 6'd1;
            if (w_last) begin
                r_q        <= w_q_final;
                r_r        <= w_r_final;
                r_div_zero <= 1'b0;
            end
        end
    end

    assign bus.q        = r_q;
    assign bus.r        = r_r;
    assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: the driver pushes expected results with their
// expected done cycle; a negedge monitor pops and compares on each done pulse.
module tb_div_32;
    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    div_32_if bus();

    div_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", bus.q, e.q);
                check("r", bus.r, e.r);
                check("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL timeout: got no done expected done within 60 cycles");
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int unsigned nb;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        bus.a = a;
        bus.b = b;
        bus.sign = s;
        bus.start = 1'b1;
        e.q = eq;
        e.r = er;
        e.dz = edz;
        e.cyc = cyc + ((b == 32'd0) ? 1 : 33);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        nb = 0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL timeout: got no done expected done within 60 cycles");
            sb.delete();
        end
        check("busy_cycles", nb, (b == 32'd0) ? 32'd0 : 32'd32);
        repeat (2) @(negedge clk);
        check("q_hold", bus.q, eq);
        check("r_hold", bus.r, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nb;
        exp_t e;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sign = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_q", bus.q, 32'd0);
        check("rst_r", bus.r, 32'd0);
        check("rst_dz", {31'd0, bus.div_zero}, 32'd0);

        // First op issued in the very cycle reset drops.
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
        run_op(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        run_op(32'd1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd1234, 1'b1);
        run_op(32'hDEADBEEF, 32'h10, 1'b0, 32'h0DEADBEE, 32'hF, 1'b0);
        run_op(32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0);
        run_op(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0);
`ifdef DIV_SIGNED_EN
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
        run_op(32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
`else
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0);
`endif

        // Start during RUN is ignored; start coinciding with done is ignored.
        @(negedge clk);
        bus.a = 32'd9;
        bus.b = 32'd3;
        bus.sign = 1'b0;
        bus.start = 1'b1;
        e.q = 32'd3;
        e.r = 32'd0;
        e.dz = 1'b0;
        e.cyc = cyc + 33;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.a = 32'd8;
        bus.b = 32'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 60 && bus.done !== 1'b1; i++) @(negedge clk);
        bus.a = 32'd50;
        bus.b = 32'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        nb = 0;
        for (int i = 0; i < 45; i++) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
        end
        check("ignored_start_busy", nb, 32'd0);
        check("ignored_start_q", bus.q, 32'd3);

        // Reset in the middle of a run: abort with no done pulse.
        @(negedge clk);
        bus.a = 32'd100;
        bus.b = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_q", bus.q, 32'd0);
        check("abort_r", bus.r, 32'd0);
        rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
        end
        check("abort_busy_after", nb, 32'd0);
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
